// File: rtl/register_file.sv
// register_file: 2R1W MIPS GPR file with $0 hardwired to zero; REGFILE_DEBUG_PORT_EN adds a third read port.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [ADDR_WIDTH-1:0] dbg_reg,
  output logic [DATA_WIDTH-1:0] dbg_data,
`endif
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);
  localparam int N = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [1:N-1];
  logic [DATA_WIDTH-1:0] view [N];
  logic [N-1:1] wen;
  assign wen = reg_write ? (N-1)'((N'(1) << write_reg) >> 1) : '0;
  always_ff @(posedge clk)
    for (int i = 1; i < N; i++)
      if (!rst_n) regs[i] <= '0;
      else if (wen[i]) regs[i] <= write_data;
  // Index 0 is a constant, so every read mux sees a full in-range table.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < N; i++) view[i] = regs[i];
  end
  assign read_data1 = view[read_reg1];
  assign read_data2 = view[read_reg2];
`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = view[dbg_reg];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: vector table, directed corner cases and random traffic against an array model.
module tb_register_file;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1, reg_write = 1'b0;
  logic [4:0]  write_reg = '0, read_reg1 = '0, read_reg2 = '0;
  logic [31:0] write_data = '0, read_data1, read_data2;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  dbg_reg = '0;
  logic [31:0] dbg_data;
`endif
  logic [31:0] model [32];
  int checks = 0, errors = 0;

  register_file dut (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data),
`ifdef REGFILE_DEBUG_PORT_EN
    .dbg_reg(dbg_reg), .dbg_data(dbg_data),
`endif
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rn, we;
    logic [4:0] wr;
    logic [31:0] wd;
    logic [4:0] a, b;
    logic [31:0] ea, eb;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
    rst_n = rn; reg_write = we; write_reg = wr; write_data = wd;
    read_reg1 = a; read_reg2 = b;
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (!rst_n) for (int i = 0; i < 32; i++) model[i] = '0;
    else if (reg_write && write_reg != 5'd0) model[write_reg] = write_data;
    @(negedge clk);
  endtask

  task automatic tick(input logic rn, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
    drive(rn, we, wr, wd, a, b);
    edge_update();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    vecs[0] = '{1'b1, 1'b1, 5'd5,  32'h12345678, 5'd5, 5'd31, 32'h12345678, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd5, 5'd31, 32'h12345678, 32'hFFFFFFFF};
    vecs[2] = '{1'b1, 1'b1, 5'd0,  32'hA5A5A5A5, 5'd0, 5'd0,  32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 5'd7,  32'h00000077, 5'd7, 5'd6,  32'h0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 5'd9,  32'h00000001, 5'd9, 5'd5,  32'h1, 32'h12345678};
    vecs[5] = '{1'b1, 1'b1, 5'd9,  32'h00000002, 5'd9, 5'd9,  32'h2, 32'h2};
    vecs[6] = '{1'b0, 1'b1, 5'd3,  32'h00000055, 5'd3, 5'd5,  32'h0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 5'd3,  32'h00000055, 5'd3, 5'd31, 32'h55, 32'h0};

    @(negedge clk);
    tick(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i); #1;
      chk($sformatf("init_rd1[%0d]", i), read_data1, 32'h0);
      chk($sformatf("init_rd2[%0d]", 31 - i), read_data2, 32'h0);
    end

    for (int i = 1; i < 32; i++) tick(1'b1, 1'b1, 5'(i), 32'hDEADBEEF, 5'(i), 5'd0);
    read_reg1 = 5'd17; read_reg2 = 5'd31; #1;
    chk("fill_rd1", read_data1, 32'hDEADBEEF);
    chk("fill_rd2", read_data2, 32'hDEADBEEF);
    tick(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(i); #1;
      chk($sformatf("rst_clear_rd1[%0d]", i), read_data1, 32'h0);
      chk($sformatf("rst_clear_rd2[%0d]", i), read_data2, 32'h0);
    end

    foreach (vecs[k]) begin
      tick(vecs[k].rn, vecs[k].we, vecs[k].wr, vecs[k].wd, vecs[k].a, vecs[k].b);
      chk($sformatf("vec%0d_rd1", k), read_data1, vecs[k].ea);
      chk($sformatf("vec%0d_rd2", k), read_data2, vecs[k].eb);
    end

    drive(1'b1, 1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0); #1;
    chk("zero_pre_rd1", read_data1, 32'h0);
    chk("zero_pre_rd2", read_data2, 32'h0);
    edge_update();
    chk("zero_post_rd1", read_data1, 32'h0);
    chk("zero_post_rd2", read_data2, 32'h0);

    tick(1'b1, 1'b1, 5'd9, 32'h1, 5'd9, 5'd0);
    drive(1'b1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd0); #1;
    chk("rdw_pre", read_data1, 32'h1);
    edge_update();
    chk("rdw_post", read_data1, 32'h2);

    tick(1'b1, 1'b1, 5'd12, 32'hAAAA0001, 5'd12, 5'd0);
    tick(1'b1, 1'b1, 5'd12, 32'hAAAA0002, 5'd12, 5'd12);
    chk("b2b_last_wins", read_data2, 32'hAAAA0002);

    drive(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd0);
    edge_update();
    chk("rst_prio", read_data1, 32'h0);
    drive(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd0); #1;
    chk("rst_release_pre", read_data1, 32'h0);
    edge_update();
    chk("rst_release_post", read_data1, 32'h55);

    tick(1'b1, 1'b1, 5'd5, 32'h12345678, 5'd7, 5'd5);
    tick(1'b1, 1'b0, 5'd7, 32'h77, 5'd7, 5'd5);
    chk("we_gate", read_data1, 32'h0);
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_reg = 5'd5; #1;
    chk("dbg_r5", dbg_data, 32'h12345678);
    dbg_reg = 5'd0; #1;
    chk("dbg_r0", dbg_data, 32'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [31:0] wd;
      logic [4:0] a, b;
      wd = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      a = 5'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
      drive($urandom_range(0, 31) != 0, 1'($urandom), 5'($urandom), wd, a, b);
`ifdef REGFILE_DEBUG_PORT_EN
      dbg_reg = 5'($urandom);
`endif
      #1;
      chk($sformatf("rnd%0d_pre_rd1", n), read_data1, model[a]);
      chk($sformatf("rnd%0d_pre_rd2", n), read_data2, model[b]);
      edge_update();
      chk($sformatf("rnd%0d_post_rd1", n), read_data1, model[a]);
      chk($sformatf("rnd%0d_post_rd2", n), read_data2, model[b]);
`ifdef REGFILE_DEBUG_PORT_EN
      chk($sformatf("rnd%0d_dbg", n), dbg_data, model[dbg_reg]);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
